// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, blanking, offset-adjustable syncs,
// line/frame pulses, optional interlace field flag and a raster interrupt.
module video_timing_gen #(
  parameter int W         = 9,
  parameter int HTOTAL    = 383,
  parameter int HBL_START = 256,
  parameter int HBL_END   = 0,
  parameter int HS_START  = 264,
  parameter int HS_END    = 288,
  parameter int VTOTAL    = 288,
  parameter int VBL_START = 241,
  parameter int VBL_END   = 17,
  parameter int VS_START  = 244,
  parameter int VS_END    = 254,
  parameter int SYNC_POL  = 1,
  parameter int INTERLACE = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce_pix,
  input  logic signed [3:0]  hs_offset,
  input  logic signed [3:0]  vs_offset,
  input  logic [W-1:0]       irq_line,
  input  logic               irq_ack,
  output logic [W-1:0]       hc,
  output logic [W-1:0]       vc,
  output logic               hsync,
  output logic               vsync,
  output logic               hbl,
  output logic               vbl,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic               field,
  output logic               raster_irq
);

  localparam logic [W-1:0] H_LAST = W'(HTOTAL);
  localparam logic [W-1:0] V_LAST = W'(VTOTAL);
  localparam logic [W-1:0] HB_ON  = W'(HBL_START);
  localparam logic [W-1:0] HB_OFF = W'(HBL_END);
  localparam logic [W-1:0] VB_ON  = W'(VBL_START);
  localparam logic [W-1:0] VB_OFF = W'(VBL_END);
  localparam logic [W-1:0] HS_ON  = W'(HS_START);
  localparam logic [W-1:0] HS_OFF = W'(HS_END);
  localparam logic [W-1:0] VS_ON  = W'(VS_START);
  localparam logic [W-1:0] VS_OFF = W'(VS_END);

  // Edge position with a sign-extended offset, wrapping modulo 2^W.
  function automatic logic [W-1:0] edge_pos(input logic [W-1:0] base,
                                            input logic signed [3:0] off);
    logic [W-1:0] off_ext;
    off_ext = {{(W-4){off[3]}}, off};
    return base + off_ext;
  endfunction

  logic signed [3:0] ho_p0, vo_p0;
  logic              hs_act_p0, vs_act_p0;
  logic [W-1:0]      hs_on, hs_off, vs_on, vs_off, v_next;
  logic              h_wrap, v_wrap;
  logic              hbl_nxt, vbl_nxt, hs_nxt, vs_nxt, irq_set;

  always_comb begin
    h_wrap  = (hc == H_LAST);
    v_wrap  = (vc == V_LAST);
    v_next  = v_wrap ? '0 : vc + 1'b1;
    hs_on   = edge_pos(HS_ON,  ho_p0);
    hs_off  = edge_pos(HS_OFF, ho_p0);
    vs_on   = edge_pos(VS_ON,  vo_p0);
    vs_off  = edge_pos(VS_OFF, vo_p0);

    hbl_nxt = hbl;
    if (hc == HB_ON)       hbl_nxt = 1'b1;
    else if (hc == HB_OFF) hbl_nxt = 1'b0;

    hs_nxt = hs_act_p0;
    if (hc == hs_on)       hs_nxt = 1'b1;
    else if (hc == hs_off) hs_nxt = 1'b0;

    // Vertical events are evaluated once per line, on the line-wrap pixel.
    vbl_nxt = vbl;
    vs_nxt  = vs_act_p0;
    if (h_wrap) begin
      if (vc == VB_ON)       vbl_nxt = 1'b1;
      else if (vc == VB_OFF) vbl_nxt = 1'b0;
      if (vc == vs_on)       vs_nxt  = 1'b1;
      else if (vc == vs_off) vs_nxt  = 1'b0;
    end

    irq_set = ce_pix && h_wrap && (v_next == irq_line);
  end

  // Counter / timing register stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc          <= '0;
      vc          <= '0;
      ho_p0       <= '0;
      vo_p0       <= '0;
      hbl         <= 1'b0;
      vbl         <= 1'b0;
      de          <= 1'b1;
      hs_act_p0   <= 1'b0;
      vs_act_p0   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      field       <= 1'b0;
      raster_irq  <= 1'b0;
    end else begin
      if (ce_pix) begin
        hc          <= h_wrap ? '0 : hc + 1'b1;
        if (h_wrap) vc <= v_next;
        hbl         <= hbl_nxt;
        vbl         <= vbl_nxt;
        de          <= ~hbl_nxt & ~vbl_nxt;
        hs_act_p0   <= hs_nxt;
        vs_act_p0   <= vs_nxt;
        line_start  <= h_wrap;
        frame_start <= h_wrap & v_wrap;
        // Offsets only move sync edges from the next frame onward.
        if (h_wrap && v_wrap) begin
          ho_p0 <= hs_offset;
          vo_p0 <= vs_offset;
          if (INTERLACE != 0) field <= ~field;
        end
      end
      if (irq_set)      raster_irq <= 1'b1;
      else if (irq_ack) raster_irq <= 1'b0;
    end
  end

  assign hsync = (SYNC_POL != 0) ? hs_act_p0 : ~hs_act_p0;
  assign vsync = (SYNC_POL != 0) ? vs_act_p0 : ~vs_act_p0;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen with a reduced raster; expected outputs
// come from a position-based model and are queued per clock for comparison.
module tb_video_timing_gen;
  localparam int W = 9;
  localparam int HT = 47, HBS = 40, HBE = 0, HSS = 42, HSE = 45;
  localparam int VT = 19, VBS = 15, VBE = 2, VSS = 16, VSE = 18;
  localparam int LINE = HT + 1;
  localparam int FRAME = LINE * (VT + 1);

  logic clk = 1'b0, reset_n = 1'b1, ce_pix = 1'b0, irq_ack = 1'b0;
  logic signed [3:0] hs_offset = '0, vs_offset = '0;
  logic [W-1:0] irq_line = '0;

  logic [W-1:0] hc0, vc0, hc1, vc1;
  logic hs0, vs0, hbl0, vbl0, de0, ls0, fs0, fld0, irq0;
  logic hs1, vs1, hbl1, vbl1, de1, ls1, fs1, fld1, irq1;

  video_timing_gen #(.W(W), .HTOTAL(HT), .HBL_START(HBS), .HBL_END(HBE),
    .HS_START(HSS), .HS_END(HSE), .VTOTAL(VT), .VBL_START(VBS), .VBL_END(VBE),
    .VS_START(VSS), .VS_END(VSE), .SYNC_POL(1), .INTERLACE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .hs_offset(hs_offset),
    .vs_offset(vs_offset), .irq_line(irq_line), .irq_ack(irq_ack),
    .hc(hc0), .vc(vc0), .hsync(hs0), .vsync(vs0), .hbl(hbl0), .vbl(vbl0),
    .de(de0), .line_start(ls0), .frame_start(fs0), .field(fld0), .raster_irq(irq0));

  video_timing_gen #(.W(W), .HTOTAL(HT), .HBL_START(HBS), .HBL_END(HBE),
    .HS_START(HSS), .HS_END(HSE), .VTOTAL(VT), .VBL_START(VBS), .VBL_END(VBE),
    .VS_START(VSS), .VS_END(VSE), .SYNC_POL(0), .INTERLACE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .hs_offset(hs_offset),
    .vs_offset(vs_offset), .irq_line(irq_line), .irq_ack(irq_ack),
    .hc(hc1), .vc(vc1), .hsync(hs1), .vsync(vs1), .hbl(hbl1), .vbl(vbl1),
    .de(de1), .line_start(ls1), .frame_start(fs1), .field(fld1), .raster_irq(irq1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] hc, vc;
    logic hs, vs, hbl, vbl, de, ls, fs, fld, irq;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0, errors = 0;

  int idx;
  logic signed [3:0] ho_m, vo_m;
  logic fld_m, irq_m, hs_m, vs_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    idx = 0; ho_m = '0; vo_m = '0; fld_m = 1'b0; irq_m = 1'b0; hs_m = 1'b0; vs_m = 1'b0;
  endtask

  // Drive one clock of stimulus and queue the outputs expected after its edge.
  task automatic tick(input bit ce, input bit ack);
    exp_t e;
    int hcm, vcm, s, en, vs, ve;
    ce_pix = ce;
    irq_ack = ack;
    if (ce) begin
      idx++;
      if (idx % FRAME == 0) begin
        ho_m = hs_offset;
        vo_m = vs_offset;
        fld_m = ~fld_m;
      end
    end
    hcm = idx % LINE;
    vcm = (idx / LINE) % (VT + 1);
    if (ce && hcm == 0 && vcm == int'(irq_line) && idx > 0) irq_m = 1'b1;
    else if (ack) irq_m = 1'b0;
    s  = (HSS + int'(ho_m)) & ((1 << W) - 1);
    en = (HSE + int'(ho_m)) & ((1 << W) - 1);
    if (s <= HT && en <= HT) hs_m = (hcm > s) && (hcm <= en);
    vs = (VSS + int'(vo_m)) & ((1 << W) - 1);
    ve = (VSE + int'(vo_m)) & ((1 << W) - 1);
    if (vs <= VT && ve <= VT) vs_m = (vcm > vs) && (vcm <= ve);
    e.hc  = W'(hcm);
    e.vc  = W'(vcm);
    e.hs  = hs_m;
    e.vs  = vs_m;
    e.hbl = (hcm > HBS) || (hcm <= HBE && idx > 0);
    e.vbl = (vcm > VBS) || (vcm <= VBE && idx >= FRAME);
    e.de  = !e.hbl && !e.vbl;
    e.ls  = (hcm == 0) && (idx > 0);
    e.fs  = e.ls && (vcm == 0);
    e.fld = fld_m;
    e.irq = irq_m;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset();
    chk("rst_hc",  32'(hc0), 32'(0));  chk("rst_vc", 32'(vc0), 32'(0));
    chk("rst_hbl", 32'(hbl0), 32'(0)); chk("rst_vbl", 32'(vbl0), 32'(0));
    chk("rst_de",  32'(de0), 32'(1));  chk("rst_ls", 32'(ls0), 32'(0));
    chk("rst_fs",  32'(fs0), 32'(0));  chk("rst_field", 32'(fld0), 32'(0));
    chk("rst_irq", 32'(irq0), 32'(0));
    chk("rst_hs_pos", 32'(hs0), 32'(0)); chk("rst_vs_pos", 32'(vs0), 32'(0));
    chk("rst_hs_neg", 32'(hs1), 32'(1)); chk("rst_vs_neg", 32'(vs1), 32'(1));
    chk("rst_field1", 32'(fld1), 32'(0)); chk("rst_hc1", 32'(hc1), 32'(0));
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("hc",          32'(hc0),  32'(e.hc));
      chk("vc",          32'(vc0),  32'(e.vc));
      chk("hsync",       32'(hs0),  32'(e.hs));
      chk("vsync",       32'(vs0),  32'(e.vs));
      chk("hbl",         32'(hbl0), 32'(e.hbl));
      chk("vbl",         32'(vbl0), 32'(e.vbl));
      chk("de",          32'(de0),  32'(e.de));
      chk("line_start",  32'(ls0),  32'(e.ls));
      chk("frame_start", 32'(fs0),  32'(e.fs));
      chk("field",       32'(fld0), 32'(0));
      chk("raster_irq",  32'(irq0), 32'(e.irq));
      chk("hc_il",       32'(hc1),  32'(e.hc));
      chk("hsync_neg",   32'(hs1),  32'(!e.hs));
      chk("vsync_neg",   32'(vs1),  32'(!e.vs));
      chk("field_il",    32'(fld1), 32'(e.fld));
      chk("frame_start_il", 32'(fs1), 32'(e.fs));
    end
  end

  initial begin
    int first;
    irq_line = W'(10);
    model_reset();
    #12 reset_n = 1'b0;
    #1 check_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Frame 0: offsets change mid-frame, irq set at line 10 then acked at line 12.
    for (int k = 0; k < FRAME; k++) begin
      if (k == 300) begin hs_offset = -4'sd3; vs_offset = -4'sd2; end
      tick(1'b1, k == 12 * LINE + 5);
    end

    // Frame 1: shifted syncs; ack coincides with the irq set, later a plain ack.
    for (int k = 0; k < FRAME; k++) begin
      if (k == 710) begin irq_line = W'(25); hs_offset = 4'sd6; vs_offset = 4'sd0; end
      tick(1'b1, (k == 10 * LINE - 1) || (k == 700));
    end

    // Frame 2: hsync edges beyond the line length; pixel enable every 4th clock.
    for (int k = 0; k < 800; k++) tick(k % 4 == 0, 1'b0);

    // Mid-frame reset without a pixel enable.
    ce_pix = 1'b0;
    reset_n = 1'b0;
    #1 check_reset();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    first = -1;
    for (int k = 1; k <= FRAME + 40; k++) begin
      tick(1'b1, 1'b0);
      if (fs0 && first < 0) first = k;
    end
    chk("frame_period", 32'(first), 32'(FRAME));

    ce_pix = 1'b0;
    @(negedge clk);
    chk("queue_drained", 32'(sb_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
